cache_mem_arbiter: RTL
======================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares one backing-memory port between two line-cache requesters (port 0 = I-side, port 1 = D-side).
//  Each requester drives the same level-held handshake the L1 cache emits: address, data, rd/wr enable held until a one-cycle ready.
//  Arbitration is round-robin. A grant is held for the whole transaction. A watchdog ends hung transactions.
//  Sits between the two L1 cache instances and the SRAM/memory controller.
// PARAMETERS
//  ADDR_W          32    address width
//  DATA_W          512   line width (64-byte line)
//  TIMEOUT_CYCLES  1024  max cycles in BUSY before abort; 0 disables watchdog
// PORTS
//  clk            in   1       clock, rising edge
//  reset_n        in   1       synchronous reset, active-low
//  cN_address     in   ADDR_W  requester N address (N = 0,1)
//  cN_write_data  in   DATA_W  requester N write line
//  cN_write_en    in   1       requester N write request (level)
//  cN_read_en     in   1       requester N read request (level)
//  cN_read_data   out  DATA_W  read line returned to N; valid only while cN_ready=1
//  cN_ready       out  1       one-cycle completion pulse to N
//  cN_err         out  1       one-cycle pulse with cN_ready when the transaction timed out
//  mem_address    out  ADDR_W  downstream address
//  mem_write_data out  DATA_W  downstream write line
//  mem_write_en   out  1       downstream write (level)
//  mem_read_en    out  1       downstream read (level)
//  mem_read_data  in   DATA_W  downstream read line
//  mem_ready      in   1       downstream completion pulse
//  busy           out  1       arbiter in BUSY state
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, rr_prio=0, all outputs 0, watchdog counter=0.
//  Reset mid-transaction abandons the transaction. mem_*_en are 0 from the next cycle. No ready is issued.
//  Request for N = cN_read_en | cN_write_en. If both are set, write wins and the read is ignored.
//  IDLE:
//   - If any request is present, pick the winner: the sole requester, or rr_prio when both request.
//   - Register grant_id and the winner's address, data, wr and rd. Go to BUSY.
//   - mem_*_en rise the cycle after the request is seen. Arbitration latency is 1 cycle.
//  BUSY:
//   - mem_* outputs are driven from the registered copies and stay stable.
//   - Requester inputs are ignored. Changes to them do not reach memory.
//   - Other requesters wait and receive no ready.
//  Completion:
//   - On mem_ready=1 in BUSY, in the same cycle (combinational): c[grant]_ready=1, c[grant]_read_data=mem_read_data.
//   - At that edge: mem_*_en<=0, rr_prio<=~grant_id, state<=IDLE.
//   - Non-granted cN_ready=0 and cN_read_data=0.
//   - mem_ready in IDLE is ignored.
//  Back-to-back:
//   - A requester drops its enable at the same edge it samples ready.
//   - The earliest next grant is the cycle after the return to IDLE.
//   - A pending request from the other port gets that grant (round-robin).
//   - Sustained contention therefore alternates 0,1,0,1.
//  Watchdog (TIMEOUT_CYCLES>0):
//   - The counter clears on entry to BUSY and increments every BUSY cycle.
//   - When it reaches TIMEOUT_CYCLES-1 with no mem_ready: c[grant]_ready=1, c[grant]_err=1, read_data=0.
//   - The arbiter then goes to IDLE and flips rr_prio.
//   - mem_ready in the same cycle as timeout takes precedence: normal completion, err=0.
//  Counter width is $clog2(TIMEOUT_CYCLES+1) and saturates. It never wraps.
//  busy = (state==BUSY). Throughput is at most one transaction per (memory latency + 2) cycles.
// STRUCTURE
//  Shared package cache_arb_pkg:
//   - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e
//   - typedef struct {addr, wdata, wr, rd} mem_req_t
//   - localparam LINE_BYTES=64
//  Sub-module rr_arbiter_2: 2-way round-robin pick. Inputs req[1:0], prio. Outputs gnt_id, gnt_valid. Purely combinational.
//  Everything else, including the FSM, request register and watchdog, lives in cache_mem_arbiter.
// TESTING
//  1. Single read: c0_read_en=1, addr=0x0000_0440; memory answers ready 3 cycles later with data=0xA5..
//     -> mem_read_en high the cycle after request, c0_ready=1 with 0xA5.., c1_ready stays 0.
//  2. Simultaneous: c0_read_en and c1_write_en held from reset release (rr_prio=0)
//     -> port 0 served first, then port 1; mem_write_data equals c1_write_data; no overlap of mem_*_en.
//  3. Fairness: both ports re-request continuously for 8 transactions
//     -> grant order 0,1,0,1,0,1,0,1; each port gets 4 readys.
//  4. Timeout: TIMEOUT_CYCLES=16, memory never readies
//     -> cycle 16 of BUSY gives c0_ready=1 and c0_err=1 with data=0; the next request is granted normally.
//  5. Reset mid-op: reset_n=0 two cycles into BUSY
//     -> mem_*_en=0 next cycle, no cN_ready; after release a fresh c1 request is granted (rr_prio=0, sole requester).
//  6. Input churn: change c0_address during BUSY -> mem_address holds the originally sampled value.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the two-port line-cache to memory arbiter.
// Request records are sized for the default 32-bit address / 64-byte line.
package cache_arb_pkg;

    localparam int LINE_BYTES = 64;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = LINE_BYTES * 8;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic                  wr;
        logic                  rd;
    } mem_req_t;

endpackage

// File: rtl/cache_mem_arbiter_rr.sv
// Two-way round-robin pick: a lone requester always wins.
// When both request, prio selects the winner.
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = (req == 2'b11) ? prio : req[1];
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between the I-side (0) and D-side (1) line caches.
// Grants are round-robin, held for a whole transaction, and guarded by a watchdog.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] c0_address,
    input  logic [DATA_W-1:0] c0_write_data,
    input  logic              c0_write_en,
    input  logic              c0_read_en,
    output logic [DATA_W-1:0] c0_read_data,
    output logic              c0_ready,
    output logic              c0_err,
    input  logic [ADDR_W-1:0] c1_address,
    input  logic [DATA_W-1:0] c1_write_data,
    input  logic              c1_write_en,
    input  logic              c1_read_en,
    output logic [DATA_W-1:0] c1_read_data,
    output logic              c1_ready,
    output logic              c1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready,
    output logic              busy
);

    localparam bit             WD_EN   = (TIMEOUT_CYCLES > 0);
    localparam int             WD_W    = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX  = '1;
    localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_e      state, state_nxt;
    mem_req_t        req_q, req_sel;
    logic            grant_id, rr_prio;
    logic            gnt_id, gnt_valid;
    logic [1:0]      req_vec;
    logic [WD_W-1:0] wd_cnt;
    logic            in_busy, done, timeout, finish;

    assign req_vec = {c1_read_en | c1_write_en, c0_read_en | c0_write_en};

    rr_arbiter_2 u_rr (
        .req       (req_vec),
        .prio      (rr_prio),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Capture the winner; a write beats a simultaneous read from the same port.
    always_comb begin
        req_sel = '0;
        if (gnt_id) begin
            req_sel.addr  = ARB_ADDR_W'(c1_address);
            req_sel.wdata = ARB_DATA_W'(c1_write_data);
            req_sel.wr    = c1_write_en;
            req_sel.rd    = c1_read_en & ~c1_write_en;
        end else begin
            req_sel.addr  = ARB_ADDR_W'(c0_address);
            req_sel.wdata = ARB_DATA_W'(c0_write_data);
            req_sel.wr    = c0_write_en;
            req_sel.rd    = c0_read_en & ~c0_write_en;
        end
    end

    assign in_busy = (state == ARB_BUSY);
    assign done    = in_busy & mem_ready;
    // mem_ready on the final watchdog cycle still counts as a normal completion.
    assign timeout = WD_EN & in_busy & ~mem_ready & (wd_cnt == WD_LAST);
    assign finish  = done | timeout;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ARB_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (gnt_valid) state_nxt = ARB_BUSY;
            ARB_BUSY: if (finish)    state_nxt = ARB_IDLE;
            default:                 state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q    <= '0;
            grant_id <= 1'b0;
            rr_prio  <= 1'b0;
            wd_cnt   <= '0;
        end else if (state == ARB_IDLE) begin
            if (gnt_valid) begin
                req_q    <= req_sel;
                grant_id <= gnt_id;
                wd_cnt   <= '0;
            end
        end else begin
            if (finish) rr_prio <= ~grant_id;
            if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
        end
    end

    always_comb begin
        busy           = in_busy;
        mem_address    = req_q.addr[ADDR_W-1:0];
        mem_write_data = req_q.wdata[DATA_W-1:0];
        mem_write_en   = in_busy & req_q.wr;
        mem_read_en    = in_busy & req_q.rd;
        c0_ready       = finish & ~grant_id;
        c1_ready       = finish & grant_id;
        c0_err         = timeout & ~grant_id;
        c1_err         = timeout & grant_id;
        c0_read_data   = (done & ~grant_id) ? mem_read_data : '0;
        c1_read_data   = (done & grant_id)  ? mem_read_data : '0;
    end

endmodule
